// File: rtl/wb_pkg.sv
// Shared write-back definitions: register index width, requester ids and
// the write-port arbiter state encoding.
package wb_pkg;

  localparam int REG_IDX_W = 5;

  localparam int WB_ALU    = 0;
  localparam int WB_LOAD   = 1;
  localparam int WB_MULDIV = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } wr_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin selector: grants the first requesting index
// found searching upward from last+1, wrapping modulo N.
module rr_picker #(
  parameter int N  = 3,
  parameter int LW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [LW-1:0] last,
  output logic [LW-1:0] gnt_id,
  output logic          gnt_valid
);

  int start;
  int cand;

  // A stale pointer outside 0..N-1 behaves as if the last grant was N-1.
  always_comb begin
    gnt_id    = '0;
    gnt_valid = 1'b0;
    start     = (int'(last) >= N) ? (N - 1) : int'(last);
    cand      = 0;
    for (int k = 1; k <= N; k++) begin
      cand = (start + k) % N;
      if (!gnt_valid && req[cand]) begin
        gnt_valid = 1'b1;
        gnt_id    = LW'(cand);
      end
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the single register-file write port among the
// write-back sources, with a bounded wait on the register-file acknowledge.
module regfile_wr_arbiter
  import wb_pkg::*;
#(
  parameter int N       = 3,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N-1:0]           req,
  input  logic [REG_IDX_W*N-1:0] req_idx,
  input  logic [DW*N-1:0]        req_data,
  output logic [N-1:0]           ack,
  output logic                   ack_err,
  output logic                   reg_we,
  output logic [REG_IDX_W-1:0]   reg_idx,
  output logic [DW-1:0]          reg_data,
  input  logic                   reg_wack,
  output logic                   busy,
  output logic                   err_sticky,
  input  logic                   err_clr
);

  localparam int LW = (N > 1) ? $clog2(N) : 1;

  wr_state_t              state;
  logic [LW-1:0]          last;
  logic [LW-1:0]          grant;
  logic [7:0]             wait_cnt;
  logic [LW-1:0]          gnt_id;
  logic                   gnt_valid;
  logic [REG_IDX_W-1:0]   sel_idx;
  logic [DW-1:0]          sel_data;

  function automatic logic [N-1:0] onehot(input logic [LW-1:0] id);
    onehot     = '0;
    onehot[id] = 1'b1;
  endfunction

  rr_picker #(.N(N), .LW(LW)) u_picker (
    .req       (req),
    .last      (last),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid)
  );

  always_comb begin
    sel_idx  = req_idx[REG_IDX_W*int'(gnt_id) +: REG_IDX_W];
    sel_data = req_data[DW*int'(gnt_id) +: DW];
  end

  assign busy = (state != ST_IDLE);

  // Writes to register 0 are dropped but still acknowledged, so the requester
  // sees the same completion handshake without touching the register file.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      last       <= LW'(N - 1);
      grant      <= '0;
      wait_cnt   <= '0;
      ack        <= '0;
      ack_err    <= 1'b0;
      reg_we     <= 1'b0;
      reg_idx    <= '0;
      reg_data   <= '0;
      err_sticky <= 1'b0;
    end else begin
      if (err_clr) begin
        err_sticky <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          ack     <= '0;
          ack_err <= 1'b0;
          if (gnt_valid) begin
            grant    <= gnt_id;
            reg_idx  <= sel_idx;
            reg_data <= sel_data;
            wait_cnt <= '0;
            if (sel_idx != '0) begin
              reg_we <= 1'b1;
              state  <= ST_WRITE;
            end else begin
              ack   <= onehot(gnt_id);
              state <= ST_DONE;
            end
          end
        end
        ST_WRITE: begin
          if (reg_wack) begin
            reg_we  <= 1'b0;
            ack     <= onehot(grant);
            ack_err <= 1'b0;
            state   <= ST_DONE;
          end else if (wait_cnt == 8'(TIMEOUT - 1)) begin
            reg_we     <= 1'b0;
            ack        <= onehot(grant);
            ack_err    <= 1'b1;
            err_sticky <= 1'b1;
            state      <= ST_DONE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ST_DONE: begin
          ack     <= '0;
          ack_err <= 1'b0;
          last    <= grant;
          state   <= ST_IDLE;
        end
        default: begin
          state  <= ST_IDLE;
          reg_we <= 1'b0;
          ack    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: each scenario task drives its own
// vectors and compares against hand-computed values.
module tb_regfile_wr_arbiter;

  localparam int N       = 3;
  localparam int DW      = 32;
  localparam int TIMEOUT = 15;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req;
  logic [5*N-1:0]  req_idx;
  logic [DW*N-1:0] req_data;
  logic [N-1:0]    ack;
  logic            ack_err;
  logic            reg_we;
  logic [4:0]      reg_idx;
  logic [DW-1:0]   reg_data;
  logic            reg_wack;
  logic            busy;
  logic            err_sticky;
  logic            err_clr;

  int checks = 0;
  int errors = 0;

  regfile_wr_arbiter #(.N(N), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_idx    (req_idx),
    .req_data   (req_data),
    .ack        (ack),
    .ack_err    (ack_err),
    .reg_we     (reg_we),
    .reg_idx    (reg_idx),
    .reg_data   (reg_data),
    .reg_wack   (reg_wack),
    .busy       (busy),
    .err_sticky (err_sticky),
    .err_clr    (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and land 1ns after the rising edge for sampling/driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; req_idx = '0; req_data = '0;
    reg_wack = 1'b0; err_clr = 1'b0;
    #2;
    checks++;
    if ({ack, ack_err, reg_we, reg_idx, reg_data, busy, err_sticky} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got ack=%b ack_err=%b we=%b idx=%0d data=%h busy=%b sticky=%b required all zero",
               ack, ack_err, reg_we, reg_idx, reg_data, busy, err_sticky);
    end
    step(); step();
    rst = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0 || reg_we !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_idle: got busy=%b we=%b required 0 0", busy, reg_we);
    end
  endtask

  task automatic test_single_write();
    req_idx[4:0] = 5'd5; req_data[31:0] = 32'h1234; req = 3'b001;
    step();
    checks++;
    if (reg_we !== 1'b1 || reg_idx !== 5'd5 || reg_data !== 32'h1234 || ack !== 3'b000) begin
      errors++;
      $display("[TB] FAIL single_cycle1: got we=%b idx=%0d data=%h ack=%b required 1 5 1234 000", reg_we, reg_idx, reg_data, ack);
    end
    step();
    checks++;
    if (reg_we !== 1'b1 || reg_idx !== 5'd5 || reg_data !== 32'h1234 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL single_cycle2: got we=%b idx=%0d data=%h busy=%b required 1 5 1234 1", reg_we, reg_idx, reg_data, busy);
    end
    reg_wack = 1'b1;
    step();
    reg_wack = 1'b0; req = '0;
    checks++;
    if (reg_we !== 1'b0 || ack !== 3'b001 || ack_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_ack: got we=%b ack=%b ack_err=%b required 0 001 0", reg_we, ack, ack_err);
    end
    step();
    checks++;
    if (ack !== 3'b000 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_after: got ack=%b busy=%b required 000 0", ack, busy);
    end
  endtask

  task automatic test_contention();
    int acks;
    int id;
    int ack_cyc[6];
    int ack_id[6];
    int exp_order[6];
    exp_order = '{0, 1, 2, 0, 1, 2};
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      req_idx[5*i +: 5]   = 5'(i + 1);
      req_data[32*i +: 32] = 32'hA0 + 32'(i);
    end
    req = 3'b111; reg_wack = 1'b1;
    acks = 0;
    for (int c = 0; c < 60 && acks < 6; c++) begin
      step();
      if (ack !== 3'b000) begin
        id = (ack === 3'b001) ? 0 : (ack === 3'b010) ? 1 : (ack === 3'b100) ? 2 : -1;
        ack_id[acks]  = id;
        ack_cyc[acks] = c;
        if (id >= 0) req_data[32*id +: 32] = req_data[32*id +: 32] + 32'h100;
        acks++;
      end
    end
    req = '0; reg_wack = 1'b0;
    checks++;
    if (acks !== 6) begin
      errors++;
      $display("[TB] FAIL contention_count: got %0d acks required 6", acks);
    end
    for (int i = 0; i < acks; i++) begin
      checks++;
      if (ack_id[i] !== exp_order[i]) begin
        errors++;
        $display("[TB] FAIL contention_order[%0d]: got %0d required %0d", i, ack_id[i], exp_order[i]);
      end
    end
    for (int i = 1; i < acks; i++) begin
      checks++;
      if (ack_cyc[i] - ack_cyc[i-1] !== 3) begin
        errors++;
        $display("[TB] FAIL contention_spacing[%0d]: got %0d cycles required 3", i, ack_cyc[i] - ack_cyc[i-1]);
      end
    end
    step(); step();
  endtask

  task automatic test_reg0();
    req_idx[9:5] = 5'd0; req_data[63:32] = 32'hFFFF; req = 3'b010;
    step();
    req = '0;
    checks++;
    if (ack !== 3'b010 || reg_we !== 1'b0 || ack_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reg0_ack: got ack=%b we=%b ack_err=%b required 010 0 0", ack, reg_we, ack_err);
    end
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (reg_we !== 1'b0 || ack !== 3'b000) begin
        errors++;
        $display("[TB] FAIL reg0_quiet[%0d]: got we=%b ack=%b required 0 000", c, reg_we, ack);
      end
    end
  endtask

  task automatic test_timeout();
    int we_cnt;
    bit seen;
    req_idx[14:10] = 5'd31; req_data[95:64] = 32'hDEAD_BEEF; req = 3'b100;
    reg_wack = 1'b0;
    we_cnt = 0; seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      step();
      if (reg_we === 1'b1) we_cnt++;
      if (ack !== 3'b000) begin
        seen = 1'b1;
        req = '0;
        checks++;
        if (ack !== 3'b100 || ack_err !== 1'b1 || reg_we !== 1'b0) begin
          errors++;
          $display("[TB] FAIL timeout_ack: got ack=%b ack_err=%b we=%b required 100 1 0", ack, ack_err, reg_we);
        end
        checks++;
        if (we_cnt !== TIMEOUT) begin
          errors++;
          $display("[TB] FAIL timeout_we_cycles: got %0d required %0d", we_cnt, TIMEOUT);
        end
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL timeout_no_ack: got none in 40 cycles required ack");
      req = '0;
    end
    step(); step(); step();
    checks++;
    if (err_sticky !== 1'b1 || ack_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL timeout_sticky: got sticky=%b ack_err=%b required 1 0", err_sticky, ack_err);
    end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    checks++;
    if (err_sticky !== 1'b0) begin
      errors++;
      $display("[TB] FAIL timeout_clear: got sticky=%b required 0", err_sticky);
    end
  endtask

  task automatic test_reset_mid();
    req_idx[9:5] = 5'd7; req_data[63:32] = 32'h7777; req = 3'b010;
    step(); step();
    checks++;
    if (reg_we !== 1'b1 || reg_idx !== 5'd7) begin
      errors++;
      $display("[TB] FAIL resetmid_write: got we=%b idx=%0d required 1 7", reg_we, reg_idx);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({ack, ack_err, reg_we, reg_idx, reg_data, busy, err_sticky} !== '0) begin
      errors++;
      $display("[TB] FAIL resetmid_outputs: got ack=%b ack_err=%b we=%b idx=%0d data=%h busy=%b required all zero",
               ack, ack_err, reg_we, reg_idx, reg_data, busy);
    end
    step();
    checks++;
    if (ack !== 3'b000 || reg_we !== 1'b0) begin
      errors++;
      $display("[TB] FAIL resetmid_hold: got ack=%b we=%b required 000 0", ack, reg_we);
    end
    step();
    rst = 1'b0;
    step();
    checks++;
    if (reg_we !== 1'b1 || reg_idx !== 5'd7 || reg_data !== 32'h7777) begin
      errors++;
      $display("[TB] FAIL resetmid_regrant: got we=%b idx=%0d data=%h required 1 7 7777", reg_we, reg_idx, reg_data);
    end
    reg_wack = 1'b1;
    step();
    reg_wack = 1'b0; req = '0;
    checks++;
    if (ack !== 3'b010 || ack_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL resetmid_ack: got ack=%b ack_err=%b required 010 0", ack, ack_err);
    end
    step();
  endtask

  task automatic test_stray_wack();
    reg_wack = 1'b1;
    step();
    reg_wack = 1'b0;
    checks++;
    if (busy !== 1'b0 || ack !== 3'b000 || reg_we !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stray_idle: got busy=%b ack=%b we=%b required 0 000 0", busy, ack, reg_we);
    end
    req_idx[4:0] = 5'd0; req = 3'b001;
    step();
    req = '0; reg_wack = 1'b1;
    checks++;
    if (ack !== 3'b001 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL stray_done_entry: got ack=%b busy=%b required 001 1", ack, busy);
    end
    step();
    reg_wack = 1'b0;
    checks++;
    if (ack !== 3'b000 || busy !== 1'b0 || reg_we !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stray_done: got ack=%b busy=%b we=%b required 000 0 0", ack, busy, reg_we);
    end
    step();
    checks++;
    if (ack !== 3'b000 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stray_after: got ack=%b busy=%b required 000 0", ack, busy);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_contention();
    test_reg0();
    test_timeout();
    test_reset_mid();
    test_stray_wack();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion required finish before 200000ns");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/regfile_wr_arbiter.md
# regfile_wr_arbiter

Shares the single register-file write port among N write-back requesters: the ALU write-back stage, the load-return path and the multiply/divide unit. Each requester holds a level request with a destination index and data. The block picks one per transaction by round-robin, drives the register file's `reg_we`/`reg_wack` handshake, and returns a one-cycle acknowledge. It sits between the pipeline's write-back sources and the register file, and replaces ad-hoc per-stage write enables.

## Interface
Parameters:
- `N`, 3: number of requesters; index 0 = ALU WB, 1 = load return, 2 = mul/div.
- `DW`, 32: data width.
- `TIMEOUT`, 15: maximum cycles to wait for `reg_wack` before aborting; range 1..255.

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req`  in  N  per-requester write request (level).
- `req_idx`  in  5·N  destination register, slice i = [5i+4:5i].
- `req_data`  in  DW·N  write data, slice i = [DW·i+DW-1:DW·i].
- `ack`  out  N  one-cycle completion pulse to the granted requester.
- `ack_err`  out  1  qualifies `ack`: transaction timed out, write not confirmed.
- `reg_we`  out  1  register-file write enable.
- `reg_idx`  out  5  write index.
- `reg_data`  out  DW  write data.
- `reg_wack`  in  1  register-file write acknowledge.
- `busy`  out  1  high in any state other than IDLE.
- `err_sticky`  out  1  set on any timeout.
- `err_clr`  in  1  clears `err_sticky`; a timeout in the same cycle wins.

## Operation
- FSM states: IDLE, WRITE, DONE.
- **IDLE:**
  - If `req` is nonzero, grant the first set bit searching upward from `last+1` and wrapping modulo N.
  - Latch the grant id, `req_idx` slice and `req_data` slice.
  - If the latched idx ≠ 0: `reg_we`←1 and go to WRITE.
  - If idx = 0: no write is issued; go directly to DONE.
- **WRITE:**
  - `reg_idx`/`reg_data` hold the latched values.
  - Timeout counter increments each cycle `reg_wack` is low.
  - `reg_wack` sampled high: `reg_we`←0, go to DONE with `ack_err`←0.
  - Counter reaches TIMEOUT: `reg_we`←0, `ack_err`←1, `err_sticky`←1, go to DONE.
- **DONE:**
  - `ack[grant]` is high for exactly this cycle.
  - `last`←grant; go to IDLE.
- Requester rules:
  - Hold `req`, idx and data stable until `ack` is seen.
  - May keep `req` high with new idx/data from the cycle after `ack` for a back-to-back write.
  - Dropping `req` before `ack` is illegal; the latched transaction completes regardless.
- Round-robin pointer `last` has width clog2(N). Requests with a stale pointer value ≥ N are treated as `last` = N-1.
- `reg_wack` outside WRITE is ignored.

## Timing
- Reset values:
  - `ack`=0, `ack_err`=0, `reg_we`=0, `reg_idx`=0, `reg_data`=0.
  - `busy`=0, `err_sticky`=0, state IDLE, `last`=N-1 (requester 0 wins first), counter 0.
- Latency, request sampled at edge t:
  - `reg_we` high from t+1.
  - `reg_wack` sampled at edge t+1+k (k ≥ 0) gives `reg_we` low and `ack` high during cycle t+2+k.
  - Next grant is sampled at t+3+k at the earliest.
  - Idx-0 request: `ack` at t+1, no `reg_we` at any point.
- Throughput: one write per 3 cycles with a zero-wait register file.
- Timeout: `reg_we` stays high for exactly TIMEOUT cycles, then `ack`+`ack_err` for one cycle.
- Simultaneous requests: exactly one grant per IDLE cycle; a requester waits at most N-1 grants.
- Reset mid-WRITE: `reg_we` drops asynchronously, no `ack` is issued, and the requester must re-request.

## Structure
- Shared package `wb_pkg`:
  - `REG_IDX_W`=5.
  - Requester id constants `WB_ALU`, `WB_LOAD`, `WB_MULDIV`.
  - State enum `wr_state_t`.
- Sub-module `rr_picker`: combinational round-robin selector with inputs `req`, `last` and outputs `gnt_id`, `gnt_valid`. It is reused by the planned bus arbiter.

## Test plan
- **Single write:** `req`=001, idx=5, data=0x1234, `reg_wack` 1 cycle after `reg_we`.
  - Required: `reg_we` with idx 5 / 0x1234 for 2 cycles.
  - Required: `ack`=001 one cycle, `ack_err`=0.
- **Contention:** `req`=111 held, with new data after each `ack`, zero-wait wack.
  - Required: grant order 0,1,2,0,1,2.
  - Required: each `ack` 3 cycles apart.
- **Register 0:** `req`=010, idx=0, data=0xFFFF.
  - Required: `reg_we` never high.
  - Required: `ack`=010 on the next cycle.
- **Timeout:** TIMEOUT=15, `req`=100, idx=31, `reg_wack` held low.
  - Required: `reg_we` high exactly 15 cycles.
  - Required: `ack`=100 with `ack_err`=1 on the next cycle.
  - Required: `err_sticky`=1 until `err_clr`.
- **Reset mid-operation:** `rst` pulsed 2 cycles into WRITE for requester 1.
  - Required: `reg_we` low immediately, no `ack`, all outputs at reset values.
  - Required: after `rst` drops with `req`=010 still held, requester 1 is granted first.
- **Stray wack:** `reg_wack` pulsed in IDLE and in DONE.
  - Required: no state change, no extra `ack`.
